// File: rtl/ea_sequencer.sv
// Effective-address sequencer: borrows the shared arithmetic unit to form base + index.
// Optional build macro EA_FAST_PATH_EN skips the high-byte add when the low-byte add did not carry.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start, ALU released
// S_ADD_LO | ALU computes base_lo + index (ADR0), low byte and carry latched
// S_ADD_HI | ALU computes 0x00 + base_hi + stored carry (ADR1)
// S_DONE   | one-cycle done pulse, may accept the next start directly
module ea_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [7:0]  base_lo,
    input  logic [7:0]  base_hi,
    input  logic [7:0]  index,
    input  logic [7:0]  alu_result,
    input  logic        alu_carry,
    output logic [5:0]  alu_opcode,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_own,
    output logic        busy,
    output logic        done,
    output logic [15:0] ea,
    output logic        page_cross
);

    localparam logic [5:0] OP_ADR0 = 6'b000000;
    localparam logic [5:0] OP_ADR1 = 6'b000001;
    localparam logic [5:0] OP_NOP  = 6'b111111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADD_LO = 2'd1,
        S_ADD_HI = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       accept;
    logic       zp_q;
    logic [7:0] lo_q;
    logic [7:0] hi_q;
    logic [7:0] idx_q;
    logic       skip_hi;

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef EA_FAST_PATH_EN
    assign skip_hi = zp_q || !alu_carry;
`else
    assign skip_hi = zp_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ADD_LO;
            S_ADD_LO: state_d = skip_hi ? S_DONE : S_ADD_HI;
            S_ADD_HI: state_d = S_DONE;
            S_DONE:   state_d = start ? S_ADD_LO : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alu_opcode = OP_NOP;
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_own    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            S_ADD_LO: begin
                alu_opcode = OP_ADR0;
                alu_a      = lo_q;
                alu_b      = idx_q;
                alu_own    = 1'b1;
                busy       = 1'b1;
            end
            S_ADD_HI: begin
                alu_opcode = OP_ADR1;
                alu_b      = hi_q;
                alu_own    = 1'b1;
                busy       = 1'b1;
            end
            S_DONE:   done = 1'b1;
            default:  ;
        endcase
    end

    // Operands are frozen at acceptance so later input changes cannot leak into the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zp_q  <= 1'b0;
            lo_q  <= 8'h00;
            hi_q  <= 8'h00;
            idx_q <= 8'h00;
        end else if (accept) begin
            zp_q  <= (mode == 2'b10);
            lo_q  <= base_lo;
            hi_q  <= base_hi;
            idx_q <= (mode == 2'b00) ? 8'h00 : index;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ea         <= 16'h0000;
            page_cross <= 1'b0;
        end else begin
            case (state_q)
                S_ADD_LO: begin
                    ea[7:0]    <= alu_result;
                    page_cross <= zp_q ? 1'b0 : alu_carry;
                    // Zero-page wraps within page 0; the fast path already knows the high byte.
                    if (zp_q) begin
                        ea[15:8] <= 8'h00;
                    end else if (skip_hi) begin
                        ea[15:8] <= hi_q;
                    end
                end
                S_ADD_HI: ea[15:8] <= alu_result;
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_ea_sequencer.sv
// Self-checking bench for ea_sequencer with a behavioural arithmetic-unit model.
// Expected results are queued on issue and popped when done is observed.
module tb_ea_sequencer;

`ifdef EA_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  base_lo = 8'h00;
    logic [7:0]  base_hi = 8'h00;
    logic [7:0]  index = 8'h00;
    logic [7:0]  alu_result;
    logic        alu_carry;
    logic [5:0]  alu_opcode;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_own;
    logic        busy;
    logic        done;
    logic [15:0] ea;
    logic        page_cross;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] ea;
        logic        pc;
        int          lat;
        int          own;
    } exp_t;

    exp_t sb_q[$];

    ea_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .base_lo    (base_lo),
        .base_hi    (base_hi),
        .index      (index),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_own    (alu_own),
        .busy       (busy),
        .done       (done),
        .ea         (ea),
        .page_cross (page_cross)
    );

    always #5 clk = ~clk;

    // Arithmetic unit: ADR0 adds a+b and registers its carry; ADR1 adds a+b plus that carry.
    logic       alu_c_q = 1'b0;
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        if (alu_opcode == 6'b000001) alu_sum = alu_sum + {8'h00, alu_c_q};
    end
    assign alu_result = alu_sum[7:0];
    assign alu_carry  = alu_sum[8];
    always @(posedge clk) if (alu_opcode == 6'b000000) alu_c_q <= alu_sum[8];

    function automatic exp_t model(input logic [1:0] m, input logic [7:0] hi, input logic [7:0] lo,
                                   input logic [7:0] idx);
        exp_t       e;
        logic [7:0] ie;
        logic [8:0] ls;
        ie = (m == 2'b00) ? 8'h00 : idx;
        ls = {1'b0, lo} + {1'b0, ie};
        if (m == 2'b10) begin
            e.ea  = {8'h00, ls[7:0]};
            e.pc  = 1'b0;
            e.lat = 2;
        end else begin
            e.ea  = {hi, lo} + {8'h00, ie};
            e.pc  = ls[8];
            e.lat = (FAST && !ls[8]) ? 2 : 3;
        end
        e.own = e.lat - 1;
        return e;
    endfunction

    task automatic issue(input logic [1:0] m, input logic [7:0] hi, input logic [7:0] lo,
                         input logic [7:0] idx, input bit hold);
        @(negedge clk);
        mode = m; base_hi = hi; base_lo = lo; index = idx; start = 1'b1;
        sb_q.push_back(model(m, hi, lo, idx));
        @(posedge clk);
        #1;
        if (!hold) begin
            start   = 1'b0;
            mode    = 2'($urandom_range(3));
            base_hi = 8'($urandom_range(255));
            base_lo = 8'($urandom_range(255));
            index   = 8'($urandom_range(255));
        end
    endtask

    // Cycle c observes the interval before edge E_c, counting from the accepting edge E0.
    task automatic get_result(output int lat, output int own, output logic [15:0] ea_o,
                              output logic pc_o, output logic [21:0] w1, output logic [21:0] w2);
        lat = 0; own = 0; ea_o = 16'h0000; pc_o = 1'b0; w1 = '0; w2 = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) w1 = {alu_opcode, alu_a, alu_b};
            if (c == 2) w2 = {alu_opcode, alu_a, alu_b};
            if (alu_own) own++;
            if (done) begin
                lat = c; ea_o = ea; pc_o = page_cross;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({busy, done, alu_own, alu_opcode, alu_a, alu_b, ea, page_cross} !==
            {1'b0, 1'b0, 1'b0, 6'h3F, 8'h00, 8'h00, 16'h0000, 1'b0})
            $display("FAIL reset_outputs got busy=%b done=%b own=%b op=%h a=%h b=%h ea=%h pc=%b",
                     busy, done, alu_own, alu_opcode, alu_a, alu_b, ea, page_cross);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_page_cross();
        int lat, own; logic [15:0] e_o; logic pc; logic [21:0] w1, w2; exp_t e;
        issue(2'b01, 8'h12, 8'hF0, 8'h20, 1'b0);
        get_result(lat, own, e_o, pc, w1, w2);
        e = sb_q.pop_front();
        n_total++;
        if (e_o !== e.ea) $display("FAIL pc_ea got %h exp %h", e_o, e.ea); else n_pass++;
        n_total++;
        if (pc !== e.pc) $display("FAIL pc_flag got %b exp %b", pc, e.pc); else n_pass++;
        n_total++;
        if (lat != e.lat) $display("FAIL pc_latency got %0d exp %0d", lat, e.lat); else n_pass++;
        n_total++;
        if (own != e.own) $display("FAIL pc_own_cycles got %0d exp %0d", own, e.own); else n_pass++;
        n_total++;
        if (w1 !== {6'h00, 8'hF0, 8'h20}) $display("FAIL pc_alu_lo got %h exp %h", w1, {6'h00, 8'hF0, 8'h20});
        else n_pass++;
        n_total++;
        if (w2 !== {6'h01, 8'h00, 8'h12}) $display("FAIL pc_alu_hi got %h exp %h", w2, {6'h01, 8'h00, 8'h12});
        else n_pass++;
    endtask

    task automatic test_no_cross();
        int lat, own; logic [15:0] e_o; logic pc; logic [21:0] w1, w2; exp_t e;
        issue(2'b01, 8'h12, 8'h34, 8'h10, 1'b0);
        get_result(lat, own, e_o, pc, w1, w2);
        e = sb_q.pop_front();
        n_total++;
        if (e_o !== e.ea || pc !== e.pc) $display("FAIL nc_result got %h/%b exp %h/%b", e_o, pc, e.ea, e.pc);
        else n_pass++;
        n_total++;
        if (lat != e.lat) $display("FAIL nc_latency got %0d exp %0d", lat, e.lat); else n_pass++;
    endtask

    task automatic test_zero_page();
        int lat, own; logic [15:0] e_o; logic pc; logic [21:0] w1, w2; exp_t e;
        issue(2'b10, 8'h45, 8'hF0, 8'h20, 1'b0);
        get_result(lat, own, e_o, pc, w1, w2);
        e = sb_q.pop_front();
        n_total++;
        if (e_o !== e.ea || pc !== e.pc) $display("FAIL zp_result got %h/%b exp %h/%b", e_o, pc, e.ea, e.pc);
        else n_pass++;
        n_total++;
        if (lat != e.lat) $display("FAIL zp_latency got %0d exp %0d", lat, e.lat); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if (ea !== e.ea || done !== 1'b0) $display("FAIL zp_hold got ea=%h done=%b exp ea=%h done=0", ea, done, e.ea);
        else n_pass++;
    endtask

    task automatic test_modes();
        int lat, own; logic [15:0] e_o; logic pc; logic [21:0] w1, w2; exp_t e;
        issue(2'b11, 8'h20, 8'hFF, 8'h01, 1'b0);
        get_result(lat, own, e_o, pc, w1, w2);
        e = sb_q.pop_front();
        n_total++;
        if (e_o !== e.ea || pc !== e.pc || lat != e.lat)
            $display("FAIL mode11 got %h/%b/%0d exp %h/%b/%0d", e_o, pc, lat, e.ea, e.pc, e.lat);
        else n_pass++;
        issue(2'b00, 8'h9C, 8'hF8, 8'h77, 1'b0);
        get_result(lat, own, e_o, pc, w1, w2);
        e = sb_q.pop_front();
        n_total++;
        if (e_o !== e.ea || pc !== e.pc || lat != e.lat)
            $display("FAIL mode00 got %h/%b/%0d exp %h/%b/%0d", e_o, pc, lat, e.ea, e.pc, e.lat);
        else n_pass++;
        n_total++;
        if (w1 !== {6'h00, 8'hF8, 8'h00}) $display("FAIL mode00_index got %h exp %h", w1, {6'h00, 8'hF8, 8'h00});
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int lat; exp_t e;
        lat = 0;
        issue(2'b01, 8'h12, 8'hF0, 8'h20, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c; start = 1'b0;
                break;
            end
            start = 1'b1; mode = 2'b10; base_hi = 8'h5A; base_lo = 8'hA5; index = 8'h3C;
        end
        e = sb_q.pop_front();
        n_total++;
        if (lat != e.lat || ea !== e.ea || page_cross !== e.pc)
            $display("FAIL ignore_busy_start got %0d/%h/%b exp %0d/%h/%b", lat, ea, page_cross, e.lat, e.ea, e.pc);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ignore_back_idle got busy=%b done=%b exp 0/0", busy, done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cnt, last; exp_t e;
        cnt = 0; last = 0;
        for (int i = 0; i < 3; i++) sb_q.push_back(model(2'b00, 8'hAB, 8'hCD, 8'h55));
        issue(2'b00, 8'hAB, 8'hCD, 8'h55, 1'b1);
        for (int c = 1; c <= 40 && cnt < 4; c++) begin
            @(negedge clk);
            if (done) begin
                e = sb_q.pop_front();
                n_total++;
                if (ea !== e.ea) $display("FAIL b2b_ea pass %0d got %h exp %h", cnt, ea, e.ea); else n_pass++;
                n_total++;
                if ((c - last) != e.lat) $display("FAIL b2b_period pass %0d got %0d exp %0d", cnt, c - last, e.lat);
                else n_pass++;
                last = c; cnt++;
                if (cnt == 4) start = 1'b0;
            end
        end
        n_total++;
        if (cnt != 4) $display("FAIL b2b_count got %0d exp 4", cnt); else n_pass++;
        sb_q.delete();
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat, own, stray; logic [15:0] e_o; logic pc; logic [21:0] w1, w2; exp_t e;
        issue(2'b01, 8'h12, 8'hF0, 8'h20, 1'b0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1 || alu_opcode !== 6'h01) $display("FAIL abort_in_add_hi got busy=%b op=%h exp 1/01", busy, alu_opcode);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({busy, done, alu_own, alu_opcode, alu_a, alu_b, ea, page_cross} !==
            {1'b0, 1'b0, 1'b0, 6'h3F, 8'h00, 8'h00, 16'h0000, 1'b0})
            $display("FAIL abort_async_reset got busy=%b done=%b own=%b op=%h a=%h b=%h ea=%h pc=%b",
                     busy, done, alu_own, alu_opcode, alu_a, alu_b, ea, page_cross);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        n_total++;
        if (stray != 0) $display("FAIL abort_no_partial got %0d active cycles exp 0", stray); else n_pass++;
        issue(2'b01, 8'hFF, 8'hFF, 8'h01, 1'b0);
        get_result(lat, own, e_o, pc, w1, w2);
        e = sb_q.pop_front();
        n_total++;
        if (e_o !== e.ea || pc !== e.pc || lat != e.lat)
            $display("FAIL wrap got %h/%b/%0d exp %h/%b/%0d", e_o, pc, lat, e.ea, e.pc, e.lat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_page_cross();
        test_no_cross();
        test_zero_page();
        test_modes();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
